// File: rtl/game_pkg.sv
// Shared types for the level flow controller and its timer.
// Optional build macro: GFC_TIME_LIMIT_EN (see game_flow_ctrl.sv).
package game_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LVL_RST = 3'd1,
    PLAY    = 3'd2,
    WIN     = 3'd3,
    LOSE    = 3'd4
  } state_t;

  localparam int TIMER_MAX = 999;
  localparam int TIMER_W   = 10;

endpackage

// File: rtl/game_flow_ctrl_if.sv
// Level-flow bundle: gameplay status in, level state and controls out.
// master = upstream/game logic side, slave = game_flow_ctrl.
interface game_flow_ctrl_if;
  import game_pkg::*;

  logic               frame_start;
  logic               start_key;
  logic [3:0]         score;
  logic               p1_at_door;
  logic               p2_at_door;
  logic               p1_dead;
  logic               p2_dead;
  logic [2:0]         game_state;
  logic               level_reset;
  logic               freeze;
  logic [TIMER_W-1:0] timer_sec;
  logic               win_flash;

  modport master (
    output frame_start, start_key, score,
    output p1_at_door, p2_at_door,
    output p1_dead, p2_dead,
    input  game_state, level_reset, freeze,
    input  timer_sec, win_flash
  );

  modport slave (
    input  frame_start, start_key, score,
    input  p1_at_door, p2_at_door,
    input  p1_dead, p2_dead,
    output game_state, level_reset, freeze,
    output timer_sec, win_flash
  );

endinterface

// File: rtl/frame_sec_timer.sv
// Frame-tick to elapsed-seconds counter with clear, enable and
// saturation at TIMER_MAX; shared with the HUD.
module frame_sec_timer
  import game_pkg::*;
#(
  parameter int FPS = 60
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear_i,
  input  logic               en_i,
  input  logic               tick_i,
  output logic [TIMER_W-1:0] sec_o
);

  localparam int FW = (FPS > 1) ? $clog2(FPS) : 1;

  logic [FW-1:0]      frame_q, frame_d;
  logic [TIMER_W-1:0] sec_q, sec_d;

  always_comb begin
    frame_d = frame_q;
    sec_d   = sec_q;
    if (clear_i) begin
      frame_d = '0;
      sec_d   = '0;
    end else if (en_i && tick_i) begin
      if (frame_q == FW'(FPS - 1)) begin
        frame_d = '0;
        if (sec_q != TIMER_W'(TIMER_MAX))
          sec_d = sec_q + 1'b1;
      end else begin
        frame_d = frame_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_q <= '0;
      sec_q   <= '0;
    end else begin
      frame_q <= frame_d;
      sec_q   <= sec_d;
    end
  end

  assign sec_o = sec_q;

endmodule

// File: rtl/game_flow_ctrl.sv
// Level state machine: PLAY/WIN/LOSE, level timer, level_reset pulse.
// Define GFC_TIME_LIMIT_EN to force LOSE when timer_sec hits TIME_LIMIT.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter int GEM_TOTAL   = 4,
  parameter int FPS         = 60,
  parameter int DOOR_FRAMES = 8,
  parameter int RST_CYCLES  = 4
`ifdef GFC_TIME_LIMIT_EN
  ,parameter int TIME_LIMIT = 120
`endif
) (
  input  logic             Clk,
  input  logic             Reset,
  game_flow_ctrl_if.slave  gf
);

  localparam int DW = $clog2(DOOR_FRAMES + 1);
  localparam int RW = $clog2(RST_CYCLES + 1);

  state_t             state_q;
  logic               start_q;
  logic               level_reset_q;
  logic               freeze_q;
  logic               win_flash_q;
  logic [3:0]         flash_cnt_q;
  logic [RW-1:0]      rst_cnt_q;
  logic [DW-1:0]      door_q, door_d;
  logic [TIMER_W-1:0] sec;

  logic press, in_play, door_ok;
  logic door_full, time_up, lose_now;

  assign press   = gf.start_key & ~start_q;
  assign in_play = (state_q == PLAY);
  assign door_ok = gf.p1_at_door & gf.p2_at_door
                 & (gf.score >= 4'(GEM_TOTAL));

  // Streak restarts the same cycle any win term drops
  always_comb begin
    door_d = door_q;
    if (!in_play || !door_ok)
      door_d = '0;
    else if (gf.frame_start && door_q != DW'(DOOR_FRAMES))
      door_d = door_q + 1'b1;
  end

  assign door_full = (door_q == DW'(DOOR_FRAMES));

`ifdef GFC_TIME_LIMIT_EN
  assign time_up = (sec == TIMER_W'(TIME_LIMIT));
`else
  assign time_up = 1'b0;
`endif

  assign lose_now = gf.p1_dead | gf.p2_dead | time_up;

  frame_sec_timer #(
    .FPS (FPS)
  ) u_timer (
    .clk     (Clk),
    .rst_n   (Reset),
    .clear_i (state_q == LVL_RST),
    .en_i    (in_play),
    .tick_i  (gf.frame_start),
    .sec_o   (sec)
  );

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      level_reset_q <= 1'b0;
      freeze_q      <= 1'b1;
      win_flash_q   <= 1'b0;
      flash_cnt_q   <= '0;
      rst_cnt_q     <= '0;
      door_q        <= '0;
    end else begin
      start_q <= gf.start_key;
      door_q  <= door_d;
      unique case (state_q)
        IDLE: begin
          if (press) begin
            state_q       <= LVL_RST;
            level_reset_q <= 1'b1;
            rst_cnt_q     <= '0;
          end
        end
        LVL_RST: begin
          if (rst_cnt_q == RW'(RST_CYCLES - 1)) begin
            state_q       <= PLAY;
            level_reset_q <= 1'b0;
            freeze_q      <= 1'b0;
          end else begin
            rst_cnt_q <= rst_cnt_q + 1'b1;
          end
        end
        PLAY: begin
          if (lose_now) begin
            state_q  <= LOSE;
            freeze_q <= 1'b1;
          end else if (door_full) begin
            state_q     <= WIN;
            freeze_q    <= 1'b1;
            flash_cnt_q <= '0;
            win_flash_q <= 1'b0;
          end
        end
        WIN: begin
          if (press) begin
            state_q       <= LVL_RST;
            level_reset_q <= 1'b1;
            rst_cnt_q     <= '0;
            flash_cnt_q   <= '0;
            win_flash_q   <= 1'b0;
          end else if (gf.frame_start) begin
            flash_cnt_q <= flash_cnt_q + 1'b1;
            if (flash_cnt_q == 4'hF)
              win_flash_q <= ~win_flash_q;
          end
        end
        LOSE: begin
          if (press) begin
            state_q       <= LVL_RST;
            level_reset_q <= 1'b1;
            rst_cnt_q     <= '0;
          end
        end
        default: begin
          state_q       <= IDLE;
          level_reset_q <= 1'b0;
          freeze_q      <= 1'b1;
        end
      endcase
    end
  end

  assign gf.game_state  = state_q;
  assign gf.level_reset = level_reset_q;
  assign gf.freeze      = freeze_q;
  assign gf.timer_sec   = sec;
  assign gf.win_flash   = win_flash_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios plus a randomized
// soak against a frame/streak-level reference model.
module tb_game_flow_ctrl;
  import game_pkg::*;

  localparam int FPS  = 60;
  localparam int DOOR = 8;
  localparam int RSTC = 4;
  localparam int GEMS = 4;
`ifdef GFC_TIME_LIMIT_EN
  localparam int TL = 3;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  game_flow_ctrl_if bus();

`ifdef GFC_TIME_LIMIT_EN
  game_flow_ctrl #(.TIME_LIMIT(TL)) dut (
    .Clk   (clk),
    .Reset (rst_n),
    .gf    (bus)
  );
`else
  game_flow_ctrl dut (
    .Clk   (clk),
    .Reset (rst_n),
    .gf    (bus)
  );
`endif

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: level phase, frames played, door streak, WIN frames
  state_t m_st;
  int     m_rl, m_frames, m_streak, m_wf;
  bit     m_pk;

  task automatic m_reset();
    m_st = IDLE; m_rl = 0; m_frames = 0;
    m_streak = 0; m_wf = 0; m_pk = 0;
  endtask

  function automatic int m_timer();
    int t;
    t = m_frames / FPS;
    return (t > 999) ? 999 : t;
  endfunction

  function automatic logic [15:0] m_exp();
    logic fl;
    fl = (m_st == WIN) ? logic'((m_wf / 16) % 2) : 1'b0;
    return {m_st, m_st == LVL_RST, m_st != PLAY,
            10'(m_timer()), fl};
  endfunction

  task automatic m_update();
    bit press, dead, to, won, qual, fs;
    press = bus.start_key && !m_pk;
    m_pk  = bus.start_key;
    fs    = bus.frame_start;
    case (m_st)
      IDLE: if (press) begin m_st = LVL_RST; m_rl = RSTC; end
      LVL_RST: begin
        m_frames = 0; m_streak = 0; m_rl--;
        if (m_rl == 0) m_st = PLAY;
      end
      PLAY: begin
        dead = bus.p1_dead || bus.p2_dead;
        to   = 0;
`ifdef GFC_TIME_LIMIT_EN
        to   = (m_timer() == TL);
`endif
        won  = (m_streak >= DOOR);
        qual = bus.p1_at_door && bus.p2_at_door
               && (int'(bus.score) >= GEMS);
        if (fs) m_frames++;
        m_streak = qual ? m_streak + int'(fs) : 0;
        if (dead || to) m_st = LOSE;
        else if (won) begin m_st = WIN; m_wf = 0; end
      end
      WIN: begin
        if (press) begin m_st = LVL_RST; m_rl = RSTC; end
        else if (fs) m_wf++;
      end
      LOSE: if (press) begin m_st = LVL_RST; m_rl = RSTC; end
      default: m_st = IDLE;
    endcase
  endtask

  function automatic logic [15:0] obs();
    return {bus.game_state, bus.level_reset, bus.freeze,
            bus.timer_sec, bus.win_flash};
  endfunction

  task automatic step();
    m_update();
    @(posedge clk);
    #1;
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      bus.frame_start = 1; step();
      bus.frame_start = 0; step();
    end
  endtask

  task automatic clr_inputs();
    bus.frame_start = 0; bus.start_key = 0; bus.score = 0;
    bus.p1_at_door = 0; bus.p2_at_door = 0;
    bus.p1_dead = 0; bus.p2_dead = 0;
  endtask

  task automatic do_reset();
    clr_inputs();
    rst_n = 0;
    m_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
  endtask

  task automatic goto_play();
    bus.start_key = 1; step();
    bus.start_key = 0;
    repeat (RSTC) step();
  endtask

  task automatic test_reset();
    logic [15:0] e;
    do_reset();
    e = {IDLE, 1'b0, 1'b1, 10'd0, 1'b0};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL reset_state got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_start();
    logic [15:0] e;
    bus.start_key = 1; step();
    bus.start_key = 0;
    for (int i = 0; i < RSTC; i++) begin
      e = {LVL_RST, 1'b1, 1'b1, 10'd0, 1'b0};
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL lvl_rst_cycle%0d got=%h exp=%h", i, obs(), e);
      end
      step();
    end
    e = {PLAY, 1'b0, 1'b0, 10'd0, 1'b0};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL enter_play got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_timer();
    frames(59);
    checks++;
    if (bus.timer_sec !== 10'd0) begin
      failures++;
      $display("FAIL timer_59f got=%0d exp=0", bus.timer_sec);
    end
    frames(1);
    checks++;
    if (bus.timer_sec !== 10'd1) begin
      failures++;
      $display("FAIL timer_60f got=%0d exp=1", bus.timer_sec);
    end
    frames(60);
    checks++;
    if (obs() !== {PLAY, 1'b0, 1'b0, 10'd2, 1'b0}) begin
      failures++;
      $display("FAIL timer_120f got=%h exp=%h", obs(),
               {PLAY, 1'b0, 1'b0, 10'd2, 1'b0});
    end
  endtask

  task automatic test_door_win();
    logic [15:0] e;
    do_reset(); goto_play();
    bus.score = 3; bus.p1_at_door = 1; bus.p2_at_door = 1;
    frames(10); step();
    checks++;
    if (bus.game_state !== PLAY) begin
      failures++;
      $display("FAIL few_gems got=%0d exp=%0d", bus.game_state, PLAY);
    end
    bus.score = 4;
    frames(5);
    bus.p2_at_door = 0; step();
    bus.p2_at_door = 1;
    frames(7); step();
    checks++;
    if (bus.game_state !== PLAY) begin
      failures++;
      $display("FAIL door_restart got=%0d exp=%0d", bus.game_state, PLAY);
    end
    bus.frame_start = 1; step();
    bus.frame_start = 0; step();
    e = {WIN, 1'b0, 1'b1, 10'd0, 1'b0};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL door_win got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_win_flash();
    frames(15);
    checks++;
    if (bus.win_flash !== 1'b0) begin
      failures++;
      $display("FAIL flash_15f got=%b exp=0", bus.win_flash);
    end
    frames(1);
    checks++;
    if (bus.win_flash !== 1'b1) begin
      failures++;
      $display("FAIL flash_16f got=%b exp=1", bus.win_flash);
    end
    bus.p1_dead = 1;
    frames(16);
    bus.p1_dead = 0;
    checks++;
    if (obs() !== {WIN, 1'b0, 1'b1, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL flash_32f_dead_ignored got=%h exp=%h", obs(),
               {WIN, 1'b0, 1'b1, 10'd0, 1'b0});
    end
    bus.start_key = 1; step();
    bus.start_key = 0;
    checks++;
    if (obs() !== {LVL_RST, 1'b1, 1'b1, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL win_restart got=%h exp=%h", obs(),
               {LVL_RST, 1'b1, 1'b1, 10'd0, 1'b0});
    end
  endtask

  task automatic test_death_priority();
    do_reset(); goto_play();
    bus.score = 4; bus.p1_at_door = 1; bus.p2_at_door = 1;
    frames(7);
    bus.frame_start = 1; bus.p2_dead = 1; step();
    bus.frame_start = 0; bus.p2_dead = 0; step();
    checks++;
    if (obs() !== {LOSE, 1'b0, 1'b1, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL death_beats_win got=%h exp=%h", obs(),
               {LOSE, 1'b0, 1'b1, 10'd0, 1'b0});
    end
    frames(70);
    checks++;
    if (obs() !== {LOSE, 1'b0, 1'b1, 10'd0, 1'b0}) begin
      failures++;
      $display("FAIL lose_timer_frozen got=%h exp=%h", obs(),
               {LOSE, 1'b0, 1'b1, 10'd0, 1'b0});
    end
  endtask

  task automatic test_time_limit();
    logic [15:0] e;
    do_reset(); goto_play();
    frames(180);
`ifdef GFC_TIME_LIMIT_EN
    e = {LOSE, 1'b0, 1'b1, 10'd3, 1'b0};
`else
    e = {PLAY, 1'b0, 1'b0, 10'd3, 1'b0};
`endif
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL time_limit got=%h exp=%h", obs(), e);
    end
  endtask

  task automatic test_saturation();
`ifndef GFC_TIME_LIMIT_EN
    bus.frame_start = 1;
    repeat (999 * FPS - 180 - 1) step();
    checks++;
    if (bus.timer_sec !== 10'd998) begin
      failures++;
      $display("FAIL sat_998 got=%0d exp=998", bus.timer_sec);
    end
    repeat (1 + 200) step();
    bus.frame_start = 0;
    checks++;
    if (obs() !== {PLAY, 1'b0, 1'b0, 10'd999, 1'b0}) begin
      failures++;
      $display("FAIL sat_hold got=%h exp=%h", obs(),
               {PLAY, 1'b0, 1'b0, 10'd999, 1'b0});
    end
`endif
  endtask

  task automatic test_async_reset();
    logic [15:0] e;
    do_reset(); goto_play();
    bus.frame_start = 1;
    repeat (70) step();
    bus.frame_start = 0;
    #2 rst_n = 0;
    #1;
    e = {IDLE, 1'b0, 1'b1, 10'd0, 1'b0};
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL async_rst_play got=%h exp=%h", obs(), e);
    end
    @(posedge clk); #1; rst_n = 1; m_reset();
    bus.start_key = 1; step();
    bus.start_key = 0; step();
    #2 rst_n = 0;
    #1;
    checks++;
    if (obs() !== e) begin
      failures++;
      $display("FAIL async_rst_lvl got=%h exp=%h", obs(), e);
    end
    @(posedge clk); #1; rst_n = 1; m_reset();
  endtask

  task automatic test_random();
    int mode;
    do_reset();
    mode = 0;
    for (int c = 0; c < 4000; c++) begin
      if (c % 200 == 0) mode = int'($urandom_range(0, 1));
      bus.frame_start = ($urandom_range(0, 2) == 0);
      bus.start_key   = ($urandom_range(0, 29) == 0);
      if (mode == 0) begin
        bus.score      = 4'($urandom_range(4, 15));
        bus.p1_at_door = ($urandom_range(0, 49) != 0);
        bus.p2_at_door = 1;
        bus.p1_dead    = 0;
        bus.p2_dead    = 0;
      end else begin
        bus.score      = 4'($urandom);
        bus.p1_at_door = 1'($urandom);
        bus.p2_at_door = 1'($urandom);
        bus.p1_dead    = ($urandom_range(0, 99) == 0);
        bus.p2_dead    = ($urandom_range(0, 99) == 0);
      end
      step();
      checks++;
      if (obs() !== m_exp()) begin
        failures++;
        $display("FAIL random_c%0d got=%h exp=%h", c, obs(), m_exp());
      end
    end
  endtask

  initial begin
    clr_inputs();
    m_reset();
    test_reset();
    test_start();
    test_timer();
    test_door_win();
    test_win_flash();
    test_death_priority();
    test_time_limit();
    test_saturation();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
